// File: rtl/g16_mul_pipe.sv
// Multi-lane pipelined GF(2^4) normal-basis multiplier with MUL / SQ / MAC modes and
// valid/ready streaming. PIPE=2 adds a product register ahead of the output/accumulate stage.
module g16_mul_pipe #(
  parameter int unsigned NLANES = 4,
  parameter int unsigned PIPE   = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [1:0]          in_mode_i,
  input  logic                in_last_i,
  input  logic [4*NLANES-1:0] in_x_i,
  input  logic [4*NLANES-1:0] in_y_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [4*NLANES-1:0] out_z_o,
  output logic                out_acc_o
);

  localparam int unsigned W = 4 * NLANES;
  localparam logic [1:0] ModeSq  = 2'b01;
  localparam logic [1:0] ModeMac = 2'b10;

  function automatic logic [1:0] g4_mul(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic logic [1:0] g4_scl_n(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  function automatic logic [3:0] g16_mul(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] e;
    e = g4_scl_n(g4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
    return {g4_mul(x[3:2], y[3:2]) ^ e, g4_mul(x[1:0], y[1:0]) ^ e};
  endfunction

  logic [W-1:0] prod_in;
  logic         in_mac;

  always_comb begin
    prod_in = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      prod_in[4*i +: 4] = g16_mul(in_x_i[4*i +: 4],
                                  (in_mode_i == ModeSq) ? in_x_i[4*i +: 4] : in_y_i[4*i +: 4]);
    end
  end

  assign in_mac = (in_mode_i == ModeMac);

  // Beat presented to the final (output / accumulate) stage.
  logic         f_valid, f_mac, f_last, f_consume, f_ready, f_fire;
  logic [W-1:0] f_prod;

  logic         out_valid_q, out_valid_d;
  logic         out_acc_q, out_acc_d;
  logic [W-1:0] out_z_q, out_z_d;
  logic [W-1:0] acc_q, acc_d;

  // Non-final MAC beats only touch ACC, so they never wait for the output register.
  assign f_consume = f_mac & ~f_last;
  assign f_ready   = f_consume | ~out_valid_q | out_ready_i;
  assign f_fire    = f_valid & f_ready;

  if (PIPE == 2) begin : g_pipe2
    logic         s1_valid_q, s1_mac_q, s1_last_q;
    logic [W-1:0] s1_prod_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s1_valid_q <= 1'b0;
        s1_mac_q   <= 1'b0;
        s1_last_q  <= 1'b0;
        s1_prod_q  <= '0;
      end else if (in_ready_o) begin
        s1_valid_q <= in_valid_i;
        if (in_valid_i) begin
          s1_mac_q  <= in_mac;
          s1_last_q <= in_last_i;
          s1_prod_q <= prod_in;
        end
      end
    end

    assign f_valid    = s1_valid_q;
    assign f_mac      = s1_mac_q;
    assign f_last     = s1_last_q;
    assign f_prod     = s1_prod_q;
    assign in_ready_o = ~s1_valid_q | f_ready;
  end else begin : g_pipe1
    assign f_valid    = in_valid_i;
    assign f_mac      = in_mac;
    assign f_last     = in_last_i;
    assign f_prod     = prod_in;
    assign in_ready_o = f_ready;
  end

  always_comb begin
    out_valid_d = out_valid_q & ~out_ready_i;
    out_z_d     = out_z_q;
    out_acc_d   = out_acc_q;
    acc_d       = acc_q;
    if (f_fire) begin
      if (f_consume) begin
        acc_d = acc_q ^ f_prod;
      end else begin
        out_valid_d = 1'b1;
        out_z_d     = f_mac ? (acc_q ^ f_prod) : f_prod;
        out_acc_d   = f_mac;
        // The sum is captured in out_z, so the next sequence may start accumulating now.
        if (f_mac) acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_acc_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_z_q     <= out_z_d;
      out_acc_q   <= out_acc_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_z_o     = out_z_q;
  assign out_acc_o   = out_acc_q;

endmodule
